multi_edge_detector: RTL and testbench
======================================

# multi_edge_detector

Parametrised multi-channel edge detector for asynchronous level inputs such as pins, buttons and status lines from other clock domains. Each channel has its own synchroniser, an optional glitch filter, and rising/falling detection with a per-channel mode. Results are reported as one-cycle pulses, sticky status bits and a single interrupt line. It replaces the single-channel, unsynchronised, unfiltered edge detector in new designs.

## Interface
- `NUM_CH`, default 4: number of independent channels, ≥1.
- `SYNC_STAGES`, default 2: synchroniser flops per channel, ≥2.
- `FILTER_CYCLES`, default 3: consecutive cycles a new level must hold before it is accepted, ≥1. Used only with the filter compiled in.
- `clk`, input, 1: single clock. All state is on the posedge.
- `reset_n`, input, 1: asynchronous, active-low reset.
- `a_i`, input, NUM_CH: asynchronous level inputs.
- `mode_i`, input, NUM_CH×2: per-channel event mode of type `edge_mode_e`.
- `clear_i`, input, NUM_CH: per-channel clear of the sticky status; a bitmask, one-cycle pulses.
- `rising_edge_o`, output, NUM_CH: one-cycle rising pulse per channel, not masked by mode.
- `falling_edge_o`, output, NUM_CH: one-cycle falling pulse per channel, not masked by mode.
- `event_o`, output, NUM_CH: one-cycle event pulse per channel, qualified by mode.
- `status_o`, output, NUM_CH: sticky event flags.
- `irq_o`, output, 1: OR-reduction of `status_o`, combinational from registers.

## Operation
- **Synchroniser:** `a_i[c]` passes through `SYNC_STAGES` flops. The last stage output is `sync[c]`.
- **Filter** (per channel):
  - Registers: accepted level `filt`, counter `cnt` of width `$clog2(FILTER_CYCLES)` (minimum 1 bit).
  - Each edge, if `sync == filt`: `cnt <= 0`.
  - Else if `cnt == FILTER_CYCLES-1`: `filt <= sync`, `cnt <= 0`.
  - Otherwise: `cnt <= cnt+1`.
  - Pulses at `sync` shorter than `FILTER_CYCLES` cycles never change `filt`.
- **Detection:**
  - `prev <= filt`.
  - Rise = `filt & ~prev`; fall = `~filt & prev`. Both are registered into `rising_edge_o` and `falling_edge_o`.
- **Modes:**
  - `EDGE_OFF`: no events.
  - `EDGE_RISE`: rise only.
  - `EDGE_FALL`: fall only.
  - `EDGE_BOTH`: rise or fall.
- `event_o` is registered on the same edge as the raw pulses, using `mode_i` sampled on that edge.
- **Sticky status:** `status <= (status & ~clear_i) | event_next`. A set wins over a simultaneous clear on the same channel.
- Channels are fully independent; simultaneous events on any number of channels are all reported.

## Timing
- **Reset values:** all synchroniser flops, `filt`, `prev`, `cnt`, all outputs and `irq_o` are 0.
- **No initial-level capture:** an input held high through reset produces a rising pulse after reset release, after the full latency.
- **Filter in, latency:** if `a_i` changes before edge 1 and stays stable, `sync` changes after edge `SYNC_STAGES`, and `filt` changes at edge `SYNC_STAGES+FILTER_CYCLES`. The pulse and event are high for exactly the one cycle after edge `SYNC_STAGES+FILTER_CYCLES+1`. `status_o` rises on that same edge.
- **Filter out, latency:** the pulse is high after edge `SYNC_STAGES+1`.
- **Interrupt:** `irq_o` rises in the same cycle as the first `status_o` bit.
- **Clearing:** `clear_i` asserted before edge k drops the bit after edge k.
- **Mode change:** takes effect from the next sampling edge. Pending counter state is unaffected.
- **Reset mid-filter:** the count is discarded and detection restarts from level 0.

## Configuration
- Macro `MULTI_EDGE_DETECTOR_FILTER_EN`.
- **Defined:** the filter is instantiated as above.
- **Undefined:** `filt` is a direct alias of `sync`, `cnt` is not built, and `FILTER_CYCLES` is ignored. Latency becomes `SYNC_STAGES+1`.

## Structure
- Package `edge_det_pkg` holds:
  - `typedef enum logic [1:0] edge_mode_e {EDGE_OFF=2'b00, EDGE_RISE=2'b01, EDGE_FALL=2'b10, EDGE_BOTH=2'b11}`.
  - Parameter-legality constants: minimum `SYNC_STAGES` of 2, minimum `FILTER_CYCLES` of 1.
- Sub-module `edge_det_channel` contains the synchroniser, filter, prev register and raw pulse logic for one channel.
- The top generates `NUM_CH` instances of `edge_det_channel`. Mode qualification, status and `irq_o` are implemented in the top.

## Test plan
All scenarios use NUM_CH=4, SYNC_STAGES=2, FILTER_CYCLES=3 and the filter enabled unless stated.
- **Basic rise:**
  - Stimulus: reset; all modes `EDGE_BOTH`; `a_i[0]` goes 0→1 before edge 1.
  - Required: `rising_edge_o[0]`, `event_o[0]` and `status_o[0]` go high after edge 6. The pulses last one cycle, status stays high, `irq_o`=1.
- **Glitch rejection:**
  - Stimulus: `a_i[1]` high for 2 cycles, then low.
  - Required: no pulse and no status. Repeating with a 3-cycle high gives a rise pulse, then a fall pulse.
- **Mode masking:**
  - Stimulus: ch2 in `EDGE_FALL`, ch3 in `EDGE_OFF`; toggle both inputs high then low.
  - Required: raw pulses appear on both channels. `event_o[2]` fires on the fall only; `event_o[3]` never fires.
- **Clear collision:**
  - Stimulus: `clear_i[0]` asserted on the edge where a new ch0 event registers.
  - Required: `status_o[0]` stays 1. A later isolated clear drops it and `irq_o` falls.
- **Reset behaviour:**
  - Stimulus: `a_i`=4'hF held through reset, and a separate `reset_n` assertion mid-count.
  - Required: all outputs 0 during reset. Four rise pulses after release at latency 6. The mid-count reset discards the count and yields no pulse.
- **Filter compiled out:**
  - Stimulus: rerun the basic rise and glitch scenarios without the macro.
  - Required: latency is 3, and a 1-cycle input pulse produces a rise pulse and a fall pulse.

Source files
------------

// File: rtl/edge_det_pkg.sv
// Shared types, parameter limits and mode decode for multi_edge_detector.
package edge_det_pkg;

    typedef enum logic [1:0] {
        EDGE_OFF  = 2'b00,
        EDGE_RISE = 2'b01,
        EDGE_FALL = 2'b10,
        EDGE_BOTH = 2'b11
    } edge_mode_e;

    localparam int unsigned MinSyncStages   = 2;
    localparam int unsigned MinFilterCycles = 1;

    function automatic logic mode_qualify(edge_mode_e mode, logic rise, logic fall);
        logic hit;
        unique case (mode)
            EDGE_RISE: hit = rise;
            EDGE_FALL: hit = fall;
            EDGE_BOTH: hit = rise | fall;
            default:   hit = 1'b0;
        endcase
        return hit;
    endfunction

endpackage

// File: rtl/edge_det_channel.sv
// One channel: synchroniser, optional glitch filter and raw rise/fall detection.
// The filter is built only when MULTI_EDGE_DETECTOR_FILTER_EN is defined.
module edge_det_channel
    import edge_det_pkg::*;
#(
    parameter int unsigned SYNC_STAGES   = 2,
    parameter int unsigned FILTER_CYCLES = 3
) (
    input  logic clk,
    input  logic reset_n,
    input  logic a_i,
    output logic rise_o,
    output logic fall_o
);

    if (SYNC_STAGES < MinSyncStages || FILTER_CYCLES < MinFilterCycles) begin : g_param_check
        $error("edge_det_channel: illegal SYNC_STAGES or FILTER_CYCLES");
    end

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync;
    logic                   filt;
    logic                   prev_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], a_i};
        end
    end

    assign sync = sync_q[SYNC_STAGES-1];

`ifdef MULTI_EDGE_DETECTOR_FILTER_EN
    localparam int unsigned CntW = (FILTER_CYCLES > 1) ? $clog2(FILTER_CYCLES) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'(FILTER_CYCLES - 1);

    logic            filt_q, filt_d;
    logic [CntW-1:0] cnt_q, cnt_d;

    // A new level must persist for FILTER_CYCLES consecutive cycles to be accepted.
    always_comb begin
        filt_d = filt_q;
        cnt_d  = cnt_q;
        if (sync == filt_q) begin
            cnt_d = '0;
        end else if (cnt_q == CntMax) begin
            filt_d = sync;
            cnt_d  = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            filt_q <= 1'b0;
            cnt_q  <= '0;
        end else begin
            filt_q <= filt_d;
            cnt_q  <= cnt_d;
        end
    end

    assign filt = filt_q;
`else
    assign filt = sync;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prev_q <= 1'b0;
        end else begin
            prev_q <= filt;
        end
    end

    assign rise_o = filt & ~prev_q;
    assign fall_o = ~filt & prev_q;

endmodule

// File: rtl/multi_edge_detector.sv
// Multi-channel edge detector: per-channel pulses, mode-qualified events, sticky status, irq.
// Glitch filter is compiled in with MULTI_EDGE_DETECTOR_FILTER_EN.
module multi_edge_detector
    import edge_det_pkg::*;
#(
    parameter int unsigned NUM_CH        = 4,
    parameter int unsigned SYNC_STAGES   = 2,
    parameter int unsigned FILTER_CYCLES = 3
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic [NUM_CH-1:0]      a_i,
    input  logic [NUM_CH-1:0][1:0] mode_i,
    input  logic [NUM_CH-1:0]      clear_i,
    output logic [NUM_CH-1:0]      rising_edge_o,
    output logic [NUM_CH-1:0]      falling_edge_o,
    output logic [NUM_CH-1:0]      event_o,
    output logic [NUM_CH-1:0]      status_o,
    output logic                   irq_o
);

    logic [NUM_CH-1:0] rise_d, fall_d, event_d, status_d;
    logic [NUM_CH-1:0] rise_q, fall_q, event_q, status_q;

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        edge_det_channel #(
            .SYNC_STAGES  (SYNC_STAGES),
            .FILTER_CYCLES(FILTER_CYCLES)
        ) u_ch (
            .clk    (clk),
            .reset_n(reset_n),
            .a_i    (a_i[c]),
            .rise_o (rise_d[c]),
            .fall_o (fall_d[c])
        );
    end

    // A new event sets status even when the same channel is cleared in that cycle.
    always_comb begin
        event_d = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            event_d[c] = mode_qualify(edge_mode_e'(mode_i[c]), rise_d[c], fall_d[c]);
        end
        status_d = (status_q & ~clear_i) | event_d;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rise_q   <= '0;
            fall_q   <= '0;
            event_q  <= '0;
            status_q <= '0;
        end else begin
            rise_q   <= rise_d;
            fall_q   <= fall_d;
            event_q  <= event_d;
            status_q <= status_d;
        end
    end

    assign rising_edge_o  = rise_q;
    assign falling_edge_o = fall_q;
    assign event_o        = event_q;
    assign status_o       = status_q;
    assign irq_o          = |status_q;

endmodule

// File: tb/tb_multi_edge_detector.sv
// Self-checking bench for multi_edge_detector: cycle scoreboard, pulse-count table, corner cases.
module tb_multi_edge_detector;
    import edge_det_pkg::*;

    localparam int unsigned NCH = 4;
    localparam int unsigned SS  = 2;
    localparam int unsigned FC  = 3;
`ifdef MULTI_EDGE_DETECTOR_FILTER_EN
    localparam bit FiltOn = 1'b1;
    localparam int Lat    = SS + FC + 1;
`else
    localparam bit FiltOn = 1'b0;
    localparam int Lat    = SS + 1;
`endif
    localparam int HLen = SS + FC;

    logic                 clk = 1'b0;
    logic                 reset_n = 1'b1;
    logic [NCH-1:0]       a_i = '0;
    logic [NCH-1:0]       clear_i = '0;
    logic [NCH-1:0][1:0]  mode_i;
    logic [NCH-1:0]       rise_o, fall_o, evt_o, stat_o;
    logic                 irq_o;

    multi_edge_detector #(
        .NUM_CH       (NCH),
        .SYNC_STAGES  (SS),
        .FILTER_CYCLES(FC)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .a_i           (a_i),
        .mode_i        (mode_i),
        .clear_i       (clear_i),
        .rising_edge_o (rise_o),
        .falling_edge_o(fall_o),
        .event_o       (evt_o),
        .status_o      (stat_o),
        .irq_o         (irq_o)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [NCH-1:0] rise;
        logic [NCH-1:0] fall;
        logic [NCH-1:0] evt;
        logic [NCH-1:0] stat;
        logic           irq;
    } exp_t;

    typedef struct {
        int         ch;
        logic [1:0] mode;
        int         hi;
        int         r_f, f_f, e_f;   // expected counts, filter built
        int         r_u, f_u, e_u;   // expected counts, filter absent
    } vec_t;

    exp_t sb_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    // Reference model: history of sampled inputs; a level is accepted once FC samples agree.
    logic [NCH-1:0] hist [HLen];
    logic [NCH-1:0] m_filt, m_prev, m_rise, m_fall, m_evt, m_stat;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic qual(logic [1:0] m, logic r, logic f);
        if (m == EDGE_RISE) return r;
        if (m == EDGE_FALL) return f;
        if (m == EDGE_BOTH) return r | f;
        return 1'b0;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < HLen; k++) hist[k] = '0;
        m_filt = '0; m_prev = '0; m_rise = '0; m_fall = '0; m_evt = '0; m_stat = '0;
    endtask

    task automatic model_edge();
        logic [NCH-1:0] nr, nf, ne;
        logic all1, all0;
        for (int k = HLen - 1; k > 0; k--) hist[k] = hist[k-1];
        hist[0] = a_i;
        nr = m_filt & ~m_prev;
        nf = ~m_filt & m_prev;
        for (int c = 0; c < NCH; c++) ne[c] = qual(mode_i[c], nr[c], nf[c]);
        m_stat = (m_stat & ~clear_i) | ne;
        m_prev = m_filt;
        if (FiltOn) begin
            for (int c = 0; c < NCH; c++) begin
                all1 = 1'b1;
                all0 = 1'b1;
                for (int k = SS; k < SS + FC; k++) begin
                    all1 &= hist[k][c];
                    all0 &= ~hist[k][c];
                end
                if (all1) m_filt[c] = 1'b1;
                else if (all0) m_filt[c] = 1'b0;
            end
        end else begin
            m_filt = hist[SS-1];
        end
        m_rise = nr; m_fall = nf; m_evt = ne;
    endtask

    task automatic tick();
        exp_t e;
        if (reset_n) model_edge();
        sb_q.push_back({m_rise, m_fall, m_evt, m_stat, |m_stat});
        @(posedge clk);
        #1;
        e = sb_q.pop_front();
        check("sb_rise",   32'(rise_o), 32'(e.rise));
        check("sb_fall",   32'(fall_o), 32'(e.fall));
        check("sb_event",  32'(evt_o),  32'(e.evt));
        check("sb_status", 32'(stat_o), 32'(e.stat));
        check("sb_irq",    32'(irq_o),  32'(e.irq));
    endtask

    task automatic reset_start();
        reset_n = 1'b0;
        #1;
        model_reset();
        check("reset_outputs", 32'({rise_o, fall_o, evt_o, stat_o, irq_o}), 32'd0);
    endtask

    task automatic clear_all();
        clear_i = '1;
        tick();
        clear_i = '0;
    endtask

    vec_t vecs[6];
    int   found, cr, cf, ce;

    initial begin
        vecs[0] = '{1, EDGE_BOTH, 2, 0, 0, 0, 1, 1, 2};
        vecs[1] = '{1, EDGE_BOTH, 3, 1, 1, 2, 1, 1, 2};
        vecs[2] = '{2, EDGE_FALL, 4, 1, 1, 1, 1, 1, 1};
        vecs[3] = '{3, EDGE_OFF,  4, 1, 1, 0, 1, 1, 0};
        vecs[4] = '{0, EDGE_RISE, 1, 0, 0, 0, 1, 1, 1};
        vecs[5] = '{1, EDGE_BOTH, 5, 1, 1, 2, 1, 1, 2};

        mode_i = {NCH{EDGE_BOTH}};
        a_i    = '1;
        model_reset();
        #1;
        // Inputs held high through reset must still produce rise pulses afterwards.
        reset_start();
        repeat (3) tick();
        reset_n = 1'b1;
        found = -1;
        for (int k = 1; k <= 20; k++) begin
            tick();
            if (rise_o == 4'hF) begin
                found = k;
                break;
            end
        end
        check("reset_rise_latency", 32'(found), 32'(Lat));

        a_i = '0;
        repeat (12) tick();
        clear_all();
        check("cleared_irq", 32'(irq_o), 32'd0);

        // Basic rise on channel 0.
        a_i[0] = 1'b1;
        found = -1;
        for (int k = 1; k <= 20; k++) begin
            tick();
            if (rise_o[0]) begin
                found = k;
                break;
            end
        end
        check("basic_latency", 32'(found), 32'(Lat));
        check("basic_event", 32'(evt_o[0]), 32'd1);
        tick();
        check("basic_pulse_len", 32'(rise_o[0]), 32'd0);
        check("basic_status", 32'(stat_o[0]), 32'd1);
        check("basic_irq", 32'(irq_o), 32'd1);

        // Clear collides with a new fall event on channel 0: set wins.
        clear_all();
        a_i[0] = 1'b0;
        repeat (Lat - 1) tick();
        clear_i[0] = 1'b1;
        tick();
        clear_i = '0;
        check("collide_fall", 32'(fall_o[0]), 32'd1);
        check("collide_status", 32'(stat_o[0]), 32'd1);
        tick();
        clear_i[0] = 1'b1;
        tick();
        clear_i = '0;
        check("isolated_clear_status", 32'(stat_o), 32'd0);
        check("isolated_clear_irq", 32'(irq_o), 32'd0);

        // Pulse-width and mode table.
        for (int i = 0; i < 6; i++) begin
            clear_all();
            mode_i[vecs[i].ch] = vecs[i].mode;
            cr = 0; cf = 0; ce = 0;
            for (int k = 0; k < vecs[i].hi + 14; k++) begin
                a_i[vecs[i].ch] = (k < vecs[i].hi);
                tick();
                cr += int'(rise_o[vecs[i].ch]);
                cf += int'(fall_o[vecs[i].ch]);
                ce += int'(evt_o[vecs[i].ch]);
            end
            check($sformatf("vec%0d_rise_count", i),  32'(cr), 32'(FiltOn ? vecs[i].r_f : vecs[i].r_u));
            check($sformatf("vec%0d_fall_count", i),  32'(cf), 32'(FiltOn ? vecs[i].f_f : vecs[i].f_u));
            check($sformatf("vec%0d_event_count", i), 32'(ce), 32'(FiltOn ? vecs[i].e_f : vecs[i].e_u));
            check($sformatf("vec%0d_status", i), 32'(stat_o[vecs[i].ch]),
                  32'((FiltOn ? vecs[i].e_f : vecs[i].e_u) != 0));
            mode_i = {NCH{EDGE_BOTH}};
        end

        // Reset in the middle of a pending count discards it.
        clear_all();
        a_i[1] = 1'b1;
        repeat (3) tick();
        reset_start();
        a_i[1] = 1'b0;
        repeat (2) tick();
        reset_n = 1'b1;
        cr = 0;
        repeat (12) begin
            tick();
            cr += int'(rise_o[1]);
        end
        check("midreset_no_rise", 32'(cr), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
